// File: rtl/nicnac_bus_pkg.sv
// Shared constants and helpers for the NICNAC16 bus selector.
// Arbitration mode encodings and a conflict detector.
package nicnac_bus_pkg;

  localparam int MODE_PRIORITY = 0;
  localparam int MODE_RR       = 1;
  localparam int MAX_N         = 16;

  // True when two or more bits are set: clearing the lowest set bit leaves
  // something behind.
  function automatic logic popcount_gt1(input logic [MAX_N-1:0] v);
    return (v & (v - MAX_N'(1))) != '0;
  endfunction

endpackage

// File: rtl/rr_priority_pick.sv
// Rotating first-set-bit picker: scans req starting at start with wrap.
// Returns a one-hot grant and the matching binary index.
module rr_priority_pick #(
  parameter int N  = 4,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] start,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx
);

  logic found;
  int   j;

  always_comb begin
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    j     = 0;
    for (int k = 0; k < N; k++) begin
      j = (int'(start) + k) % N;
      if (!found && req[j]) begin
        found  = 1'b1;
        gnt[j] = 1'b1;
        idx    = IW'(j);
      end
    end
  end

endmodule

// File: rtl/bus_select_arbiter.sv
// Registered N-source bus selector with priority or round-robin pick.
// Holds the last bus value and flags multi-select conflicts.
module bus_select_arbiter
  import nicnac_bus_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int N     = 4,
  parameter int MODE  = 0
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic [N*WIDTH-1:0] DIN,
  input  logic [N-1:0]     SEL,
  input  logic             CLR_ERR,
  output logic [WIDTH-1:0] OUT,
  output logic             OUT_VALID,
  output logic [N-1:0]     GRANT,
  output logic             CONFLICT,
  output logic             CONFLICT_STICKY
);

  localparam int IW = (N > 1) ? $clog2(N) : 1;

  logic [IW-1:0]    ptr_q, ptr_d;
  logic [IW-1:0]    start;
  logic [IW-1:0]    pick_idx;
  logic [N-1:0]     pick_gnt;
  logic [WIDTH-1:0] bus;
  logic [WIDTH-1:0] out_q;
  logic             valid_q;
  logic [N-1:0]     grant_q;
  logic             conf_q;
  logic             sticky_q;
  logic [MAX_N-1:0] sel16;
  logic             any_sel;
  logic             conf_now;

  // Search begins one past the last winner; fixed priority always starts at 0.
  always_comb begin
    start = '0;
    if (MODE == MODE_RR && N > 1) begin
      start = (ptr_q == IW'(N - 1)) ? '0 : ptr_q + IW'(1);
    end
  end

  rr_priority_pick #(
    .N  (N),
    .IW (IW)
  ) u_pick (
    .req   (SEL),
    .start (start),
    .gnt   (pick_gnt),
    .idx   (pick_idx)
  );

  always_comb begin
    bus = '0;
    for (int i = 0; i < N; i++) begin
      bus = bus | ({WIDTH{pick_gnt[i]}} & DIN[i*WIDTH +: WIDTH]);
    end
  end

  always_comb begin
    sel16        = '0;
    sel16[N-1:0] = SEL;
  end

  assign any_sel  = |SEL;
  assign conf_now = popcount_gt1(sel16);
  assign ptr_d    = (any_sel && N > 1) ? pick_idx : ptr_q;

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      out_q    <= '0;
      valid_q  <= 1'b0;
      grant_q  <= '0;
      conf_q   <= 1'b0;
      sticky_q <= 1'b0;
      ptr_q    <= IW'(N - 1);
    end else begin
      if (any_sel) begin
        out_q <= bus;
      end
      valid_q  <= any_sel;
      grant_q  <= pick_gnt;
      conf_q   <= conf_now;
      sticky_q <= (sticky_q & ~CLR_ERR) | conf_now;
      ptr_q    <= ptr_d;
    end
  end

  assign OUT             = out_q;
  assign OUT_VALID       = valid_q;
  assign GRANT           = grant_q;
  assign CONFLICT        = conf_q;
  assign CONFLICT_STICKY = sticky_q;

endmodule

// File: tb/tb_bus_select_arbiter.sv
// Directed bench for bus_select_arbiter: one priority and one
// round-robin instance share the same stimulus.
module tb_bus_select_arbiter;

  localparam int W = 16;
  localparam int N = 4;

  logic           CLK = 1'b0;
  logic           RST_N;
  logic [N*W-1:0] DIN;
  logic [N-1:0]   SEL;
  logic           CLR_ERR;

  logic [W-1:0] p_out, r_out;
  logic         p_vld, r_vld;
  logic [N-1:0] p_gnt, r_gnt;
  logic         p_cf, r_cf;
  logic         p_st, r_st;

  int errs   = 0;
  int checks = 0;

  localparam logic [N*W-1:0] DIN_REF = 64'hDDDD_CCCC_BBBB_AAAA;

  always #5 CLK = ~CLK;

  bus_select_arbiter #(.WIDTH(W), .N(N), .MODE(0)) u_p (
    .CLK             (CLK),
    .RST_N           (RST_N),
    .DIN             (DIN),
    .SEL             (SEL),
    .CLR_ERR         (CLR_ERR),
    .OUT             (p_out),
    .OUT_VALID       (p_vld),
    .GRANT           (p_gnt),
    .CONFLICT        (p_cf),
    .CONFLICT_STICKY (p_st)
  );

  bus_select_arbiter #(.WIDTH(W), .N(N), .MODE(1)) u_rr (
    .CLK             (CLK),
    .RST_N           (RST_N),
    .DIN             (DIN),
    .SEL             (SEL),
    .CLR_ERR         (CLR_ERR),
    .OUT             (r_out),
    .OUT_VALID       (r_vld),
    .GRANT           (r_gnt),
    .CONFLICT        (r_cf),
    .CONFLICT_STICKY (r_st)
  );

  always @(posedge CLK) begin
    if (RST_N === 1'b1) begin
      assert (!$isunknown(SEL))
        else $error("SEL unknown while out of reset");
    end
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk_p(input string tag, input logic [W-1:0] o,
                       input logic [N-1:0] g, input logic v,
                       input logic c, input logic s);
    chk({tag, ".p.out"}, 32'(p_out), 32'(o));
    chk({tag, ".p.gnt"}, 32'(p_gnt), 32'(g));
    chk({tag, ".p.vld"}, 32'(p_vld), 32'(v));
    chk({tag, ".p.cf"},  32'(p_cf),  32'(c));
    chk({tag, ".p.st"},  32'(p_st),  32'(s));
  endtask

  task automatic chk_r(input string tag, input logic [W-1:0] o,
                       input logic [N-1:0] g, input logic v,
                       input logic c);
    chk({tag, ".r.out"}, 32'(r_out), 32'(o));
    chk({tag, ".r.gnt"}, 32'(r_gnt), 32'(g));
    chk({tag, ".r.vld"}, 32'(r_vld), 32'(v));
    chk({tag, ".r.cf"},  32'(r_cf),  32'(c));
  endtask

  task automatic do_reset();
    RST_N = 1'b0;
    tick();
    RST_N = 1'b1;
  endtask

  logic [N-1:0] rr_seq [5];

  initial begin
    RST_N   = 1'b0;
    DIN     = DIN_REF;
    SEL     = '0;
    CLR_ERR = 1'b0;
    tick();
    tick();
    chk_p("rst", 16'h0, 4'b0000, 1'b0, 1'b0, 1'b0);
    chk_r("rst", 16'h0, 4'b0000, 1'b0, 1'b0);
    chk("rst.r.st", 32'(r_st), 32'd0);
    RST_N = 1'b1;

    // Single select
    SEL = 4'b0100;
    tick();
    chk_p("s1", 16'hCCCC, 4'b0100, 1'b1, 1'b0, 1'b0);
    chk_r("s1", 16'hCCCC, 4'b0100, 1'b1, 1'b0);

    // Hold with churning DIN
    SEL = 4'b0000;
    for (int i = 0; i < 3; i++) begin
      DIN = {4{16'(16'h1234 + 16'(i * 16'h1111))}};
      tick();
      chk_p($sformatf("hold%0d", i), 16'hCCCC, 4'b0000, 1'b0, 1'b0, 1'b0);
      chk(  $sformatf("hold%0d.r.out", i), 32'(r_out), 32'hCCCC);
    end
    DIN = DIN_REF;

    // Priority conflict and sticky behaviour
    SEL = 4'b1010;
    tick();
    chk_p("cf1", 16'hBBBB, 4'b0010, 1'b1, 1'b1, 1'b1);
    SEL = 4'b0001;
    tick();
    chk_p("cf2", 16'hAAAA, 4'b0001, 1'b1, 1'b0, 1'b1);
    SEL     = 4'b0000;
    CLR_ERR = 1'b1;
    tick();
    chk_p("clr", 16'hAAAA, 4'b0000, 1'b0, 1'b0, 1'b0);
    SEL = 4'b0011;
    tick();
    chk_p("setwins", 16'hAAAA, 4'b0001, 1'b1, 1'b1, 1'b1);
    CLR_ERR = 1'b0;
    SEL     = 4'b0000;

    // Round-robin sweep from reset
    do_reset();
    chk_r("rst2", 16'h0, 4'b0000, 1'b0, 1'b0);
    rr_seq = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    SEL = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk($sformatf("rr%0d.gnt", i), 32'(r_gnt), 32'(rr_seq[i]));
      chk($sformatf("rr%0d.cf", i),  32'(r_cf),  32'd1);
      chk($sformatf("rr%0d.p", i),   32'(p_gnt), 32'b0001);
    end

    // Reset in the middle of a run
    do_reset();
    for (int i = 0; i < 3; i++) tick();
    chk("mid.pre", 32'(r_gnt), 32'b0100);
    RST_N = 1'b0;
    tick();
    chk_r("mid.rst", 16'h0, 4'b0000, 1'b0, 1'b0);
    chk("mid.rst.st", 32'(r_st), 32'd0);
    RST_N = 1'b1;
    tick();
    chk_r("mid.post", 16'hAAAA, 4'b0001, 1'b1, 1'b1);

    // Skip and wrap from ptr=2
    do_reset();
    for (int i = 0; i < 3; i++) tick();
    chk("wrap.pre", 32'(r_gnt), 32'b0100);
    SEL = 4'b0011;
    tick();
    chk_r("wrap1", 16'hAAAA, 4'b0001, 1'b1, 1'b1);
    tick();
    chk_r("wrap2", 16'hBBBB, 4'b0010, 1'b1, 1'b1);
    SEL = 4'b0000;
    tick();
    chk_r("idle", 16'hBBBB, 4'b0000, 1'b0, 1'b0);
    SEL = 4'b1111;
    tick();
    chk_r("after_idle", 16'hCCCC, 4'b0100, 1'b1, 1'b1);
    SEL = 4'b0000;
    tick();

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
